// File: rtl/stream_wrap_adapter.sv
// Stream wrap adapter: bridges a host word interface to a core stream
// interface through one small FIFO per direction. Optionally byte-swaps
// words on the way in and on the way out. Keeps transfer counters and
// sticky error flags for rejected host requests.
module stream_wrap_adapter #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             swap_en,
    input  logic             clear,

    input  logic [WIDTH-1:0] din,
    input  logic             write,
    output logic             full,

    output logic [WIDTH-1:0] dout,
    input  logic             read,
    output logic             avail,

    output logic [WIDTH-1:0] core_in_data,
    output logic             core_in_write,
    input  logic             core_in_full,

    input  logic [WIDTH-1:0] core_out_data,
    input  logic             core_out_avail,
    output logic             core_out_read,

    output logic [CNT_W-1:0] in_count,
    output logic [CNT_W-1:0] out_count,
    output logic             err_overflow,
    output logic             err_underflow
);

    localparam int          AW       = $clog2(DEPTH);
    localparam int          NB       = WIDTH / 8;
    localparam logic [AW:0] OCC_FULL = (AW + 1)'(DEPTH);

    // Reverse the byte order of a word when en is set; identity otherwise.
    function automatic logic [WIDTH-1:0] byte_swap(input logic [WIDTH-1:0] word,
                                                   input logic             en);
        logic [WIDTH-1:0] res;
        res = word;
        if (en) begin
            for (int k = 0; k < NB; k++) begin
                res[8*(NB-1-k) +: 8] = word[8*k +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Ingress FIFO (host -> core)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] in_mem [DEPTH];
    logic [AW-1:0]    in_wr_ptr;
    logic [AW-1:0]    in_rd_ptr;
    logic [AW:0]      in_occ;
    logic             in_nonempty;
    logic             in_push;
    logic             in_pop;

    // Full is judged on registered occupancy only, so a same-cycle core
    // pop never frees a slot for a host write that arrives while full.
    assign full          = (in_occ == OCC_FULL);
    assign in_nonempty   = (in_occ != '0);
    assign in_push       = write && !full;
    assign core_in_write = in_nonempty && !core_in_full;
    assign in_pop        = core_in_write;
    // Head is forced to zero when empty so it reads 0 during reset.
    assign core_in_data  = in_nonempty ? in_mem[in_rd_ptr] : '0;

    // Ingress storage: words are swapped once, at host acceptance.
    always_ff @(posedge clk) begin
        if (in_push) begin
            in_mem[in_wr_ptr] <= byte_swap(din, swap_en);
        end
    end

    // Ingress pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_occ    <= '0;
        end else begin
            if (in_push) begin
                in_wr_ptr <= in_wr_ptr + AW'(1);
            end
            if (in_pop) begin
                in_rd_ptr <= in_rd_ptr + AW'(1);
            end
            case ({in_push, in_pop})
                2'b10:   in_occ <= in_occ + (AW + 1)'(1);
                2'b01:   in_occ <= in_occ - (AW + 1)'(1);
                default: in_occ <= in_occ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Egress FIFO (core -> host)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] eg_mem [DEPTH];
    logic [AW-1:0]    eg_wr_ptr;
    logic [AW-1:0]    eg_rd_ptr;
    logic [AW:0]      eg_occ;
    logic             eg_push;
    logic             eg_pop;

    assign avail   = (eg_occ != '0);
    assign eg_push = core_out_avail && (eg_occ < OCC_FULL);
    assign eg_pop  = read && avail;
    // The strobe to the core is masked while reset is held; internally the
    // push is harmless then because all control state is held cleared.
    assign core_out_read = eg_push && !rst;
    assign dout          = avail ? eg_mem[eg_rd_ptr] : '0;

    // Egress storage: words are swapped once, at capture from the core.
    always_ff @(posedge clk) begin
        if (eg_push) begin
            eg_mem[eg_wr_ptr] <= byte_swap(core_out_data, swap_en);
        end
    end

    // Egress pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eg_wr_ptr <= '0;
            eg_rd_ptr <= '0;
            eg_occ    <= '0;
        end else begin
            if (eg_push) begin
                eg_wr_ptr <= eg_wr_ptr + AW'(1);
            end
            if (eg_pop) begin
                eg_rd_ptr <= eg_rd_ptr + AW'(1);
            end
            case ({eg_push, eg_pop})
                2'b10:   eg_occ <= eg_occ + (AW + 1)'(1);
                2'b01:   eg_occ <= eg_occ - (AW + 1)'(1);
                default: eg_occ <= eg_occ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------

    // Accepted-write counter; clear has priority over a same-cycle count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_count <= '0;
        end else if (clear) begin
            in_count <= '0;
        end else if (in_push) begin
            in_count <= in_count + CNT_W'(1);
        end
    end

    // Performed-read counter; clear has priority over a same-cycle count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_count <= '0;
        end else if (clear) begin
            out_count <= '0;
        end else if (eg_pop) begin
            out_count <= out_count + CNT_W'(1);
        end
    end

    // Sticky flags for rejected host requests; the rejected word is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else if (clear) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (write && full) begin
                err_overflow <= 1'b1;
            end
            if (read && !avail) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_wrap_adapter.sv
// Testbench for stream_wrap_adapter: queue-based reference model with a
// scoreboard, randomized traffic plus directed corner scenarios, and a
// small 32-bit instance for byte-swap checks on wider words.
module tb_stream_wrap_adapter;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMOD  = 1 << CNT_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic             rst, swap_en, clear, write, read, core_in_full, core_out_avail;
    logic [WIDTH-1:0] din, core_out_data;
    logic             full, avail, core_in_write, core_out_read, err_overflow, err_underflow;
    logic [WIDTH-1:0] dout, core_in_data;
    logic [CNT_W-1:0] in_count, out_count;

    // 32-bit instance signals
    logic        b_rst, b_swap, b_clear, b_write, b_read, b_cif, b_coa;
    logic [31:0] b_din, b_cod, b_dout, b_cid;
    logic        b_full, b_avail, b_ciw, b_cor, b_ovf, b_unf;
    logic [7:0]  b_in_count, b_out_count;

    stream_wrap_adapter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .swap_en(swap_en), .clear(clear),
        .din(din), .write(write), .full(full),
        .dout(dout), .read(read), .avail(avail),
        .core_in_data(core_in_data), .core_in_write(core_in_write), .core_in_full(core_in_full),
        .core_out_data(core_out_data), .core_out_avail(core_out_avail), .core_out_read(core_out_read),
        .in_count(in_count), .out_count(out_count),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    stream_wrap_adapter #(.WIDTH(32), .DEPTH(2), .CNT_W(8)) dut32 (
        .clk(clk), .rst(b_rst), .swap_en(b_swap), .clear(b_clear),
        .din(b_din), .write(b_write), .full(b_full),
        .dout(b_dout), .read(b_read), .avail(b_avail),
        .core_in_data(b_cid), .core_in_write(b_ciw), .core_in_full(b_cif),
        .core_out_data(b_cod), .core_out_avail(b_coa), .core_out_read(b_cor),
        .in_count(b_in_count), .out_count(b_out_count),
        .err_overflow(b_ovf), .err_underflow(b_unf)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [WIDTH-1:0] exp_in_q[$];
    logic [WIDTH-1:0] exp_out_q[$];
    int m_in_occ = 0, m_eg_occ = 0, m_in_cnt = 0, m_out_cnt = 0;
    bit m_ovf = 0, m_unf = 0;
    bit exp_full = 0, exp_avail = 0, exp_ciw = 0, exp_cor = 0;
    bit drv_tick = 0, cnt_tick = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sw16(input logic [15:0] w, input logic s);
        return s ? {w[7:0], w[15:8]} : w;
    endfunction

    // One host/core cycle: drive inputs at the falling edge and advance the
    // model to its state after the coming rising edge.
    task automatic drive_cycle(input logic w, input logic [15:0] d, input logic r,
                               input logic cif, input logic coa, input logic [15:0] cod,
                               input logic sw, input logic clr);
        bit acc, rd;
        @(negedge clk);
        write = w; din = d; read = r; core_in_full = cif;
        core_out_avail = coa; core_out_data = cod; swap_en = sw; clear = clr;
        exp_full  = (m_in_occ == DEPTH);
        exp_avail = (m_eg_occ != 0);
        exp_ciw   = (m_in_occ != 0) && !cif;
        exp_cor   = coa && (m_eg_occ < DEPTH);
        acc = w && !exp_full;
        rd  = r && exp_avail;
        if (acc)     exp_in_q.push_back(sw16(d, sw));
        if (exp_cor) exp_out_q.push_back(sw16(cod, sw));
        m_in_occ = m_in_occ + int'(acc) - int'(exp_ciw);
        m_eg_occ = m_eg_occ + int'(exp_cor) - int'(rd);
        if (clr) begin
            m_in_cnt = 0; m_out_cnt = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (acc) m_in_cnt = (m_in_cnt + 1) % CMOD;
            if (rd)  m_out_cnt = (m_out_cnt + 1) % CMOD;
            if (w && exp_full) m_ovf = 1;
            if (r && !exp_avail) m_unf = 1;
        end
        drv_tick = 1;
        cnt_tick = 1;
    endtask

    task automatic idle_cycle(input logic cif);
        drive_cycle(1'b0, 16'h0, 1'b0, cif, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    // Handshake/data monitor: compares whenever the DUT presents a word.
    always @(negedge clk) begin
        #2;
        if (drv_tick) begin
            drv_tick = 0;
            check("full", full, exp_full);
            check("avail", avail, exp_avail);
            check("core_in_write", core_in_write, exp_ciw);
            check("core_out_read", core_out_read, exp_cor);
            if (core_in_write) begin
                if (exp_in_q.size() == 0) check("core_in_data_unexpected", 1, 0);
                else check("core_in_data", core_in_data, exp_in_q.pop_front());
            end
            if (read && avail) begin
                if (exp_out_q.size() == 0) check("dout_unexpected", 1, 0);
                else check("dout", dout, exp_out_q.pop_front());
            end
        end
    end

    // Counter/flag monitor: compares state just after each active edge.
    always @(posedge clk) begin
        #1;
        if (cnt_tick) begin
            cnt_tick = 0;
            check("in_count", in_count, m_in_cnt);
            check("out_count", out_count, m_out_cnt);
            check("err_overflow", err_overflow, m_ovf);
            check("err_underflow", err_underflow, m_unf);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1; swap_en = 0; clear = 0; write = 0; read = 0; din = '0;
        core_in_full = 0; core_out_avail = 1; core_out_data = 16'h5555;
        b_rst = 1; b_swap = 0; b_clear = 0; b_write = 0; b_read = 0;
        b_cif = 0; b_coa = 0; b_din = '0; b_cod = '0;

        // reset state, with core offering data to prove the strobe is masked
        #2;
        check("rst_full", full, 0);
        check("rst_avail", avail, 0);
        check("rst_core_in_write", core_in_write, 0);
        check("rst_core_out_read", core_out_read, 0);
        check("rst_dout", dout, 0);
        check("rst_core_in_data", core_in_data, 0);
        check("rst_in_count", in_count, 0);
        check("rst_out_count", out_count, 0);
        check("rst_err_overflow", err_overflow, 0);
        check("rst_err_underflow", err_underflow, 0);
        @(negedge clk);
        core_out_avail = 0;
        @(negedge clk);
        rst = 0;

        // swapped write appears one cycle later
        drive_cycle(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        idle_cycle(1'b0);
        #1;
        check("swap_head", core_in_data, 16'h3412);
        check("swap_head_valid", core_in_write, 1);

        // five writes with core blocked: fifth dropped, then drain in order
        for (int i = 0; i < 5; i++)
            drive_cycle(1'b1, 16'hA0 + 16'(i), 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        check("full_after_4", full, 1);
        @(posedge clk); #2;
        check("overflow_set", err_overflow, 1);
        for (int i = 0; i < 5; i++) idle_cycle(1'b0);

        // underflow, then clear with a word held in the ingress FIFO
        drive_cycle(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        drive_cycle(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        drive_cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        idle_cycle(1'b0);
        idle_cycle(1'b0);

        // counter wrap: 17 accepted writes
        drive_cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++)
            drive_cycle(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0, 16'h0, 1'($urandom), 1'b0);
        @(posedge clk); #2;
        check("in_count_wrap", in_count, 1);

        // randomized traffic
        for (int i = 0; i < 800; i++)
            drive_cycle($urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 9) < 5,
                        $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6, 16'($urandom),
                        1'($urandom), $urandom_range(0, 99) < 3);

        // drain, then buffer words in both directions and reset mid-cycle
        for (int i = 0; i < 20 && (m_in_occ != 0 || m_eg_occ != 0); i++)
            drive_cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, 16'hC0 + 16'(i), 1'b0, 1'b1, 1'b1, 16'hD0 + 16'(i), 1'b0, 1'b0);
        @(posedge clk); #2;
        write = 0; read = 0; core_out_avail = 0; core_in_full = 0;
        #1;
        check("pre_rst_core_in_write", core_in_write, 1);
        check("pre_rst_avail", avail, 1);
        rst = 1;
        #1;
        check("async_rst_full", full, 0);
        check("async_rst_avail", avail, 0);
        check("async_rst_core_in_write", core_in_write, 0);
        check("async_rst_dout", dout, 0);
        check("async_rst_core_in_data", core_in_data, 0);
        check("async_rst_in_count", in_count, 0);
        exp_in_q.delete(); exp_out_q.delete();
        m_in_occ = 0; m_eg_occ = 0; m_in_cnt = 0; m_out_cnt = 0; m_ovf = 0; m_unf = 0;
        exp_full = 0; exp_avail = 0; exp_ciw = 0; exp_cor = 0;
        @(negedge clk);
        rst = 0;
        drive_cycle(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle_cycle(1'b0);

        // 32-bit instance: egress swap on capture, ingress swap on accept
        @(negedge clk);
        b_rst = 0;
        @(negedge clk);
        b_swap = 1; b_coa = 1; b_cod = 32'hAABBCCDD;
        #2;
        check("w32_core_out_read", b_cor, 1);
        @(negedge clk);
        b_coa = 0;
        #2;
        check("w32_avail", b_avail, 1);
        check("w32_dout_swapped", b_dout, 32'hDDCCBBAA);
        b_read = 1;
        @(negedge clk);
        b_read = 0;
        #2;
        check("w32_avail_after_read", b_avail, 0);
        check("w32_out_count", b_out_count, 1);
        @(negedge clk);
        b_swap = 0; b_coa = 1;
        @(negedge clk);
        b_coa = 0;
        #2;
        check("w32_dout_plain", b_dout, 32'hAABBCCDD);
        b_read = 1;
        @(negedge clk);
        b_read = 0; b_swap = 1; b_write = 1; b_din = 32'h11223344;
        #2;
        check("w32_out_count_2", b_out_count, 2);
        @(negedge clk);
        b_write = 0;
        #2;
        check("w32_core_in_write", b_ciw, 1);
        check("w32_core_in_data", b_cid, 32'h44332211);
        check("w32_in_count", b_in_count, 1);

        @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_wrap_adapter.md
STREAM_WRAP_ADAPTER -- requirements
Module: stream_wrap_adapter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: channel word width in bits, a multiple of 8 and at least 8.
REQ-002 SHALL have parameter DEPTH, default 4: entries per direction FIFO, a power of 2 and at least 2.
REQ-003 SHALL have parameter CNT_W, default 32: width of the transfer counters.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 swap_en  input  1  1 = reverse byte order of each word in both directions.
REQ-007 clear  input  1  synchronous clear of counters and error flags.
REQ-008 din  input  WIDTH  host write data.
REQ-009 write  input  1  host write request.
REQ-010 full  output  1  ingress FIFO full.
REQ-011 dout  output  WIDTH  host read data, the egress FIFO head.
REQ-012 read  input  1  host read request.
REQ-013 avail  output  1  egress FIFO non-empty.
REQ-014 core_in_data  output  WIDTH  ingress FIFO head to core.
REQ-015 core_in_write  output  1  core push strobe.
REQ-016 core_in_full  input  1  core input full.
REQ-017 core_out_data  input  WIDTH  core output word.
REQ-018 core_out_avail  input  1  core output available.
REQ-019 core_out_read  output  1  core pop strobe.
REQ-020 in_count, out_count  output  CNT_W each  words accepted from host and words delivered to host.
REQ-021 err_overflow, err_underflow  output  1 each  sticky error flags.

Function
REQ-022 Byte swap SHALL map byte k of a word to byte (WIDTH/8-1-k) when swap_en=1, and SHALL pass the word through unchanged when swap_en=0.
REQ-023 Ingress swap SHALL be applied at host acceptance, and egress swap SHALL be applied at capture from the core, using swap_en in that cycle.
REQ-024 Host write SHALL be accepted if and only if write && !full.
REQ-025 An accepted word SHALL be stored in the ingress FIFO and SHALL first appear on core_in_data one cycle later.
REQ-026 full SHALL be 1 exactly when the registered ingress occupancy equals DEPTH.
REQ-027 A core pop in the same cycle SHALL NOT make room for a host write while full=1.
REQ-028 core_in_write SHALL be (ingress non-empty && !core_in_full), combinational from registered state.
REQ-029 core_in_data SHALL equal the ingress head whenever core_in_write=1.
REQ-030 When core_in_write=1, the head SHALL be popped at that edge.
REQ-031 core_out_read SHALL be (core_out_avail && egress occupancy < DEPTH).
REQ-032 When core_out_read=1, the swapped core_out_data SHALL be pushed into the egress FIFO.
REQ-033 avail SHALL equal (egress occupancy != 0).
REQ-034 dout SHALL equal the egress head.
REQ-035 A host read SHALL be performed if and only if read && avail, popping the head at that edge.
REQ-036 Simultaneous push and pop on a non-empty, non-full FIFO SHALL leave occupancy unchanged and preserve word order.
REQ-037 Pointers SHALL wrap modulo DEPTH, with occupancy tracked in log2(DEPTH)+1 bits.
REQ-038 in_count SHALL increment on each accepted host write, out_count SHALL increment on each performed host read, and both SHALL wrap modulo 2^CNT_W.
REQ-039 write && full SHALL set err_overflow.
REQ-040 read && !avail SHALL set err_underflow.
REQ-041 The rejected word in REQ-039 and REQ-040 SHALL be dropped, and no FIFO state SHALL change.
REQ-042 clear=1 SHALL zero both counters and both flags at the next edge.
REQ-043 When clear coincides with a counted event, clear SHALL win and the counter SHALL be 0.
REQ-044 clear SHALL NOT affect FIFO contents.

Reset
REQ-045 rst=1 SHALL immediately, without waiting for clk, empty both FIFOs and zero pointers, counters and flags.
REQ-046 During and after reset: full=0, avail=0, core_in_write=0, core_out_read=0, in_count=0, out_count=0, err_overflow=0, err_underflow=0.
REQ-047 dout and core_in_data SHALL be 0 during reset.
REQ-048 Reset mid-transfer SHALL discard all buffered words.
REQ-049 The first accepted word after release SHALL be the next word written.

Verification
REQ-050 WIDTH=16, swap_en=1, core_in_full=0, write din=16'h1234 -> core_in_write=1 with core_in_data=16'h3412 exactly one cycle later; in_count=1.
REQ-051 WIDTH=32, swap_en=1, core_out_data=32'hAABBCCDD avail, host reads -> dout=32'hDDCCBBAA, out_count=1; with swap_en=0 -> dout=32'hAABBCCDD.
REQ-052 DEPTH=4, core_in_full=1, 5 consecutive writes -> full=1 after the 4th; the 5th is dropped and err_overflow=1; release core_in_full -> 4 words emerge in order and full=0 after the first pop.
REQ-053 Read with avail=0 -> err_underflow=1, out_count unchanged; then clear=1 for one cycle -> both flags=0 and both counters=0, with FIFO contents intact.
REQ-054 rst asserted between clock edges while 3 words are buffered -> full, avail and core_in_write drop to 0 without a clock edge; after release, the next write 16'h0001 is the first word delivered.
REQ-055 CNT_W=4, 17 accepted writes -> in_count=1 (wrap).
